ifq_fetch_resp: RTL
===================

Name: ifq_fetch_resp

Overview:
Instruction-memory responder on the fetch side of the instruction fetch queue controller.
- Accepts line-fetch requests (cache_en) and returns a burst of LINE_WORDS sequential instruction words on dout/dout_valid after a fixed latency.
- Maintains the fetch PC and redirects it on branch_valid.
- Stalls on FIFO backpressure.
- Sits between the instruction store and the fetch FIFO push side.

Parameters:
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W words.
- DATA_W, 32, instruction width.
- LINE_WORDS, 4, words per burst; power of two, 1..8.
- LAT, 2, cycles from request capture to first valid word; valid range 1..15.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- cache_en  in  1  line-fetch request, sampled only in IDLE.
- branch_valid  in  1  redirect/flush request, highest priority.
- branch_addr  in  ADDR_W  redirect target word address.
- stall  in  1  FIFO full/backpressure; freezes the burst.
- wr_en  in  1  loader write strobe.
- wr_addr  in  ADDR_W  loader write address.
- wr_data  in  DATA_W  loader write data.
- dout  out  DATA_W  instruction word, registered.
- dout_valid  out  1  dout is valid this cycle, registered.
- dout_pc  out  ADDR_W  word address of dout, registered.
- busy  out  1  high in WAIT or BURST.
- line_done  out  1  one-cycle pulse coincident with the last word of a burst.

Behaviour:
Reset (reset low, async):
- state=IDLE, pc=RESET_PC, word_cnt=0, lat_cnt=0.
- dout=0, dout_valid=0, dout_pc=0, busy=0, line_done=0.
- Memory contents are not reset.

Memory:
- Synchronous write: wr_en at edge writes mem[wr_addr].
- Reads are combinational from pc inside the BURST datapath, registered into dout.
- A write and a read to the same address in the same cycle returns the old data.

States:
- IDLE
  - branch_valid -> FLUSH.
  - else cache_en -> WAIT, with lat_cnt=LAT-1, word_cnt=0.
  - else stay in IDLE.
- WAIT
  - branch_valid -> FLUSH.
  - else if lat_cnt==0 -> BURST.
  - else decrement lat_cnt.
  - stall does not affect WAIT.
- BURST, per cycle:
  - branch_valid -> FLUSH; the word is not emitted.
  - else if stall: dout_valid=0, and pc/word_cnt hold.
  - else emit: dout=mem[pc], dout_pc=pc, dout_valid=1, pc=pc+1, word_cnt+1.
  - When the last word is emitted (word_cnt==LINE_WORDS-1), line_done=1 and the next state is IDLE.
- FLUSH (one cycle)
  - pc<=branch_addr, captured on the edge entering FLUSH.
  - dout_valid=0 and the burst is aborted; the next state is IDLE.
  - branch_valid asserted in FLUSH re-captures branch_addr and stays in FLUSH.

Timing and arithmetic:
- Latency: cache_en captured at edge E0 gives the first dout_valid after edge E0+LAT+1 when stall is low.
- An unstalled burst is LINE_WORDS consecutive valid cycles.
- pc wraps modulo 2**ADDR_W; e.g. 0xFF+1 -> 0x00 in mid-burst.
- cache_en outside IDLE is ignored; it is not queued.
- busy = (state==WAIT || state==BURST), decoded from registered state.
- line_done never asserts on aborted bursts.
- In every non-emitting cycle, dout_valid=0 while dout and dout_pc hold their last values.

Optional Feature:
IFQ_FETCH_RESP_PARITY_EN
- Defined:
  - Memory stores DATA_W+1 bits; the extra bit is ^wr_data computed at write time.
  - Extra output dout_perr (1 bit, registered with dout) is high when the stored parity differs from ^dout of the read word.
  - Extra input par_inject (1 bit): when high during a write, the stored parity bit is inverted, for test.
  - dout_perr is 0 at reset and whenever dout_valid=0.
- Undefined: the ports and the parity storage are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ifq_pkg:
  - state enum (IDLE, WAIT, BURST, FLUSH), typedef'd fetch_state_t.
  - localparams for the default ADDR_W and DATA_W.
  - typedef inst_t (logic [DATA_W-1:0]).
- One sub-module, ifq_inst_mem: the synchronous-write / async-read array, including the parity bit under the macro.
- FSM, counters and output registers live in ifq_fetch_resp.

Test Plan:
1. Load mem[0..7]=0x100..0x107, reset, pulse cache_en at E0 with LAT=2 -> dout_valid high after E3..E6; dout=0x100..0x103, dout_pc=0..3; line_done only with 0x103; then busy=0.
2. Hold stall high for 2 cycles after the 2nd word -> dout_valid low 2 cycles, then 0x102, 0x103; no word skipped or duplicated.
3. Assert branch_valid with branch_addr=0x40 during the 2nd burst word -> FLUSH, no further dout_valid, line_done=0. Next cache_en returns mem[0x40..0x43].
4. Set pc=0xFE via branch, request -> dout_pc sequence 0xFE, 0xFF, 0x00, 0x01.
5. Pulse cache_en during WAIT and BURST -> ignored, exactly LINE_WORDS words returned. Drive reset low mid-burst -> all outputs 0 immediately; after release pc=RESET_PC.
6. With IFQ_FETCH_RESP_PARITY_EN, write 0x5 with par_inject=1, fetch it -> dout_perr=1 on that word only.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared fetch-responder state type and default widths
package ifq_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, WAIT, BURST, FLUSH} fetch_state_t;
    typedef logic [DATA_W_DEF-1:0] inst_t;
endpackage

// File: rtl/ifq_fetch_resp_if.sv
// ifq_fetch_resp_if: request, loader and response bundle; parity pins only with IFQ_FETCH_RESP_PARITY_EN
interface ifq_fetch_resp_if import ifq_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cache_en;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_addr;
    logic              stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W-1:0] dout_pc;
    logic              busy;
    logic              line_done;
`ifdef IFQ_FETCH_RESP_PARITY_EN
    logic              par_inject;
    logic              dout_perr;
    modport master (output cache_en, branch_valid, branch_addr, stall, wr_en, wr_addr, wr_data, par_inject,
                    input dout, dout_valid, dout_pc, busy, line_done, dout_perr);
    modport slave  (input cache_en, branch_valid, branch_addr, stall, wr_en, wr_addr, wr_data, par_inject,
                    output dout, dout_valid, dout_pc, busy, line_done, dout_perr);
`else
    modport master (output cache_en, branch_valid, branch_addr, stall, wr_en, wr_addr, wr_data,
                    input dout, dout_valid, dout_pc, busy, line_done);
    modport slave  (input cache_en, branch_valid, branch_addr, stall, wr_en, wr_addr, wr_data,
                    output dout, dout_valid, dout_pc, busy, line_done);
`endif
endinterface

// File: rtl/ifq_inst_mem.sv
// ifq_inst_mem: sync-write/async-read instruction store; stores a parity bit with IFQ_FETCH_RESP_PARITY_EN
module ifq_inst_mem import ifq_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef IFQ_FETCH_RESP_PARITY_EN
    input  logic              par_inject,
    output logic              rd_perr,
`endif
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
`ifdef IFQ_FETCH_RESP_PARITY_EN
    logic [DATA_W:0] mem [0:(1<<ADDR_W)-1];
    // loader write; parity computed here, optionally inverted to exercise the checker
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {^wr_data ^ par_inject, wr_data};
    end
    assign rd_data = mem[rd_addr][DATA_W-1:0];
    assign rd_perr = mem[rd_addr][DATA_W] != ^rd_data;
`else
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    // loader write; reads see the pre-write contents within the same cycle
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
    assign rd_data = mem[rd_addr];
`endif
endmodule

// File: rtl/ifq_fetch_resp.sv
// ifq_fetch_resp: fetch-side line responder with PC redirect and backpressure; optional IFQ_FETCH_RESP_PARITY_EN
module ifq_fetch_resp import ifq_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LINE_WORDS = 4,
    parameter int LAT        = 2,
    parameter int RESET_PC   = 0
) (
    input logic            clk,
    input logic            reset,
    ifq_fetch_resp_if.slave bus
);
    localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        word_cnt;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              last;
`ifdef IFQ_FETCH_RESP_PARITY_EN
    logic              rd_perr;
`endif

    ifq_inst_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk(clk),
        .wr_en(bus.wr_en),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_data),
`ifdef IFQ_FETCH_RESP_PARITY_EN
        .par_inject(bus.par_inject),
        .rd_perr(rd_perr),
`endif
        .rd_addr(pc),
        .rd_data(rd_data)
    );

    assign last     = word_cnt == 4'(LINE_WORDS - 1);
    assign bus.busy = state == WAIT || state == BURST;

    // FSM, counters and registered outputs; a redirect overrides everything else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pc             <= PC0;
            word_cnt       <= '0;
            lat_cnt        <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_pc    <= '0;
            bus.line_done  <= 1'b0;
`ifdef IFQ_FETCH_RESP_PARITY_EN
            bus.dout_perr  <= 1'b0;
`endif
        end else begin
            bus.dout_valid <= 1'b0;
            bus.line_done  <= 1'b0;
`ifdef IFQ_FETCH_RESP_PARITY_EN
            bus.dout_perr  <= 1'b0;
`endif
            if (bus.branch_valid) begin
                state <= FLUSH;
                pc    <= bus.branch_addr;
            end else begin
                case (state)
                    IDLE: if (bus.cache_en) begin
                        state    <= WAIT;
                        lat_cnt  <= 4'(LAT - 1);
                        word_cnt <= '0;
                    end
                    WAIT: if (lat_cnt == 4'd0) state <= BURST;
                          else lat_cnt <= lat_cnt - 4'd1;
                    BURST: if (!bus.stall) begin
                        bus.dout       <= rd_data;
                        bus.dout_pc    <= pc;
                        bus.dout_valid <= 1'b1;
`ifdef IFQ_FETCH_RESP_PARITY_EN
                        bus.dout_perr  <= rd_perr;
`endif
                        pc             <= pc + ADDR_W'(1);
                        word_cnt       <= word_cnt + 4'd1;
                        if (last) begin
                            bus.line_done <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
